div3_seq: RTL and testbench
===========================

// Module: div3_seq
// PURPOSE
//  Sequential restoring divider by a constant: returns quotient and remainder of an unsigned operand.
//  The quotient counterpart of the combinational mod-3 reducer in the ALU datapath.
//  Produces one quotient bit per clock and uses a start/busy/done handshake.
//  Sits beside the ALU so that divide-by-constant ops share one registered result interface.
// PARAMETERS
//  num_width  8  operand, quotient and remainder width in bits
//  DIVISOR    3  constant divisor; legal range 1..2**num_width-1; DIVISOR==0 is an elaboration error
// PORTS
//  clk        in   1          single clock, rising edge
//  rst        in   1          synchronous, active-high reset
//  enable     in   1          block enable; low = start ignored, in-flight op aborted
//  start      in   1          request; sampled only in IDLE while enable=1
//  number     in   num_width  dividend; latched on the accepted-start edge
//  busy       out  1          high while state==CALC
//  done       out  1          one-cycle pulse; quotient/remainder valid from this cycle on
//  quotient   out  num_width  number / DIVISOR
//  remainder  out  num_width  number % DIVISOR (always < DIVISOR)
//  chk_err    out  1          present only with DIV_RESIDUE_CHECK_EN (see CONFIGURATION)
// BEHAVIOUR
//  - All state is registered. Reset is synchronous and active-high (rst) on the single clock clk.
//  - Reset values: state=IDLE, busy=0, done=0, quotient=0, remainder=0, chk_err=0.
//  - FSM states: IDLE, CALC.
//      IDLE->CALC when enable&&start. Latch number, clear partial remainder, load bit counter to num_width-1.
//      CALC: on each edge, shift the next dividend bit (MSB first) into the partial remainder (num_width+1 bits wide).
//            If the partial remainder is >= DIVISOR, subtract DIVISOR and set the quotient bit to 1; otherwise set it to 0.
//      CALC->IDLE on the edge that processes bit 0: register quotient/remainder and set done=1 for one cycle.
//      CALC->IDLE when enable==0: abort. No done pulse. Outputs keep their previous result.
//  - Latency: start accepted at edge 0 -> busy=1 after edge 0 -> done=1 after edge num_width (8 by default).
//    done is high for exactly one cycle. busy is 0 in the done cycle.
//  - Back-to-back: start high in the done cycle is accepted (FSM is already IDLE). Throughput is one op per num_width+1 cycles.
//  - start while busy is ignored and not queued. number changes during CALC have no effect.
//  - quotient/remainder hold their last result until the next successful completion or a reset.
//  - rst during CALC: return to IDLE with all outputs at their reset values on the next edge. rst wins over start.
//  - Arithmetic is unsigned. The quotient fits in num_width bits because DIVISOR>=1.
// CONFIGURATION
//  `define DIV_RESIDUE_CHECK_EN
//   With the macro defined: on the completion edge the block also computes quotient*DIVISOR+remainder (2*num_width bits).
//   It compares this with the latched dividend and with remainder<DIVISOR.
//   On a mismatch, chk_err is set (sticky) and stays set until rst.
//   Without the macro: chk_err is not a port and no check logic is built. All other timing is identical.
// TESTING
//  1 rst, then start with number=200 -> done after exactly 8 edges, quotient=66, remainder=2, busy=0 during done.
//  2 Exhaustive 0..255 back-to-back, start held high -> one done every 9 cycles.
//    Expect quotient=n/3 and remainder=n%3 in every case, e.g. 0->(0,0), 255->(85,0), 254->(84,2).
//  3 start=1 with number=99 at cycle 3 of the op (busy) -> ignored; the result is that of the first operand only, and there is exactly one done.
//  4 enable dropped in the 4th CALC cycle -> busy=0 on the next edge, no done, previous result unchanged.
//    A subsequent start with enable=1 completes normally.
//  5 rst pulsed in CALC, together with start -> IDLE, quotient=remainder=0, no done. A start after rst is released is accepted.
//  6 With DIV_RESIDUE_CHECK_EN, repeat scenario 2 -> chk_err stays 0.
//    Force a corrupted remainder -> chk_err=1 and stays 1 until rst.

Source files
------------

// File: rtl/div3_seq.sv
// Sequential restoring divider by a constant DIVISOR, one quotient bit per clock, start/busy/done handshake.
// Optional residue self-check of each result is built when DIV_RESIDUE_CHECK_EN is defined (adds chk_err).
`timescale 1ns/1ps

module div3_seq #(
    parameter int unsigned num_width = 8,
    parameter int unsigned DIVISOR   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 start,
    input  logic [num_width-1:0] number,
    output logic                 busy,
    output logic                 done,
    output logic [num_width-1:0] quotient,
    output logic [num_width-1:0] remainder
`ifdef DIV_RESIDUE_CHECK_EN
    ,
    output logic                 chk_err
`endif
);

    localparam int unsigned CNT_W = (num_width > 1) ? $clog2(num_width) : 1;
    localparam logic [num_width:0]   DIV_EXT  = (num_width + 1)'(DIVISOR);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(num_width - 1);

    generate
        if (DIVISOR == 0) begin : g_div_zero
            $error("div3_seq: DIVISOR must be nonzero");
        end
        if ((DIVISOR >> num_width) != 0) begin : g_div_wide
            $error("div3_seq: DIVISOR must fit in num_width bits");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    state_t               state, state_nxt;
    logic [num_width-1:0] dividend_p0, dividend_nxt;
    logic [num_width-1:0] prem, prem_nxt;
    logic [num_width-1:0] qacc, qacc_nxt;
    logic [CNT_W-1:0]     bit_cnt, bit_cnt_nxt;
    logic [num_width-1:0] quo_nxt, rem_nxt;
    logic                 done_nxt;
    logic [num_width:0]   trial;
    logic [num_width:0]   step_rem;
    logic                 qbit;

    // One restoring step: subtract the divisor when it fits and report the quotient bit.
    function automatic logic [num_width:0] restore_step(input logic [num_width:0] partial,
                                                        output logic q);
        if (partial >= DIV_EXT) begin
            q = 1'b1;
            return partial - DIV_EXT;
        end
        q = 1'b0;
        return partial;
    endfunction

    always_comb begin
        state_nxt    = state;
        dividend_nxt = dividend_p0;
        prem_nxt     = prem;
        qacc_nxt     = qacc;
        bit_cnt_nxt  = bit_cnt;
        quo_nxt      = quotient;
        rem_nxt      = remainder;
        done_nxt     = 1'b0;
        qbit         = 1'b0;
        trial        = {prem, dividend_p0[bit_cnt]};
        step_rem     = restore_step(trial, qbit);

        case (state)
            IDLE: begin
                if (enable && start) begin
                    state_nxt    = CALC;
                    dividend_nxt = number;
                    prem_nxt     = '0;
                    qacc_nxt     = '0;
                    bit_cnt_nxt  = CNT_LAST;
                end
            end
            CALC: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else begin
                    prem_nxt    = step_rem[num_width-1:0];
                    qacc_nxt    = (qacc << 1) | num_width'(qbit);
                    bit_cnt_nxt = bit_cnt - 1'b1;
                    if (bit_cnt == '0) begin
                        state_nxt = IDLE;
                        quo_nxt   = (qacc << 1) | num_width'(qbit);
                        rem_nxt   = step_rem[num_width-1:0];
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Result/handshake registers carry reset values; the working datapath does not need them.
    always_ff @(posedge clk) begin
        if (rst) begin
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            done      <= done_nxt;
            quotient  <= quo_nxt;
            remainder <= rem_nxt;
        end
        dividend_p0 <= dividend_nxt;
        prem        <= prem_nxt;
        qacc        <= qacc_nxt;
        bit_cnt     <= bit_cnt_nxt;
    end

    assign busy = (state == CALC);

`ifdef DIV_RESIDUE_CHECK_EN
    logic [2*num_width-1:0] recon;
    logic                   chk_fail;

    always_comb begin
        recon    = (2*num_width)'(quo_nxt) * (2*num_width)'(DIVISOR) + (2*num_width)'(rem_nxt);
        chk_fail = (recon != (2*num_width)'(dividend_p0)) || ({1'b0, rem_nxt} >= DIV_EXT);
    end

    // Sticky until reset so a single bad result is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_err <= 1'b0;
        end else if (done_nxt && chk_fail) begin
            chk_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_div3_seq.sv
// Directed bench for div3_seq: latency, exhaustive back-to-back, ignored start, abort, reset, residue check.
`timescale 1ns/1ps

module tb_div3_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic         start;
    logic [W-1:0] number;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
`ifdef DIV_RESIDUE_CHECK_EN
    logic         chk_err;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    div3_seq #(.num_width(W), .DIVISOR(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .start     (start),
        .number    (number),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
`ifdef DIV_RESIDUE_CHECK_EN
        ,
        .chk_err   (chk_err)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int limit, output int edges);
        edges = 0;
        while (edges < limit) begin
            tick();
            edges++;
            if (done) return;
        end
        chk("done_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic count_dones(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (done) cnt++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int edges;
        int cnt;

        rst    = 1'b1;
        enable = 1'b1;
        start  = 1'b0;
        number = '0;
        repeat (3) tick();
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_q", {24'd0, quotient}, 0);
        chk("rst_r", {24'd0, remainder}, 0);
        rst = 1'b0;
        tick();

        // Single op: 200 / 3 = 66 r 2, done 8 edges after acceptance.
        number = 8'd200;
        start  = 1'b1;
        tick();
        start = 1'b0;
        chk("s1_busy", {31'd0, busy}, 1);
        wait_done(20, edges);
        chk("s1_lat", edges, 8);
        chk("s1_q", {24'd0, quotient}, 66);
        chk("s1_r", {24'd0, remainder}, 2);
        chk("s1_busy_in_done", {31'd0, busy}, 0);
        tick();
        chk("s1_done_one_cycle", {31'd0, done}, 0);

        // Exhaustive back-to-back with start held high: one result every 9 edges.
        number = 8'd0;
        start  = 1'b1;
        for (int n = 0; n < 256; n++) begin
            wait_done(30, edges);
            chk($sformatf("s2_lat_%0d", n), edges, 9);
            chk($sformatf("s2_q_%0d", n), {24'd0, quotient}, n / 3);
            chk($sformatf("s2_r_%0d", n), {24'd0, remainder}, n % 3);
            if (n < 255) number = W'(n + 1);
            else start = 1'b0;
        end
`ifdef DIV_RESIDUE_CHECK_EN
        chk("s6_clean_chk_err", {31'd0, chk_err}, 0);
`endif
        tick();

        // Start while busy is ignored; number changes in CALC have no effect.
        number = 8'd50;
        start  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        start  = 1'b1;
        number = 8'd99;
        tick();
        start = 1'b0;
        chk("s3_busy", {31'd0, busy}, 1);
        wait_done(20, edges);
        chk("s3_lat", edges, 5);
        chk("s3_q", {24'd0, quotient}, 16);
        chk("s3_r", {24'd0, remainder}, 2);
        count_dones(20, cnt);
        chk("s3_extra_done", cnt, 0);

        // Enable dropped in the 4th CALC cycle aborts without done.
        number = 8'd100;
        start  = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        enable = 1'b0;
        tick();
        chk("s4_busy_abort", {31'd0, busy}, 0);
        chk("s4_done_abort", {31'd0, done}, 0);
        count_dones(15, cnt);
        chk("s4_no_done", cnt, 0);
        chk("s4_q_hold", {24'd0, quotient}, 16);
        chk("s4_r_hold", {24'd0, remainder}, 2);
        enable = 1'b1;
        start  = 1'b1;
        tick();
        start = 1'b0;
        wait_done(20, edges);
        chk("s4_lat", edges, 8);
        chk("s4_q", {24'd0, quotient}, 33);
        chk("s4_r", {24'd0, remainder}, 1);

        // Reset during CALC together with start.
        number = 8'd77;
        start  = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        rst   = 1'b1;
        start = 1'b1;
        tick();
        chk("s5_busy", {31'd0, busy}, 0);
        chk("s5_done", {31'd0, done}, 0);
        chk("s5_q", {24'd0, quotient}, 0);
        chk("s5_r", {24'd0, remainder}, 0);
        tick();
        chk("s5_rst_wins", {31'd0, busy}, 0);
        rst = 1'b0;
        tick();
        start = 1'b0;
        chk("s5_accept", {31'd0, busy}, 1);
        wait_done(20, edges);
        chk("s5_lat", edges, 8);
        chk("s5_q_after", {24'd0, quotient}, 25);
        chk("s5_r_after", {24'd0, remainder}, 2);

`ifdef DIV_RESIDUE_CHECK_EN
        // Corrupted remainder must raise the sticky residue error.
        tick();
        number = 8'd10;
        start  = 1'b1;
        force dut.rem_nxt = 8'd3;
        tick();
        start = 1'b0;
        wait_done(20, edges);
        release dut.rem_nxt;
        chk("s6_err_set", {31'd0, chk_err}, 1);
        number = 8'd9;
        start  = 1'b1;
        tick();
        start = 1'b0;
        wait_done(20, edges);
        chk("s6_err_sticky", {31'd0, chk_err}, 1);
        chk("s6_q_clean", {24'd0, quotient}, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("s6_err_rst", {31'd0, chk_err}, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
